fetch_ifid_stage: RTL

- Instruction fetch stage plus IF/ID pipeline register, directly upstream of the immediate generator and decoder.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched word to ID as id_instr, the field source for immediate extraction; also presents its PC.
- Honours ID stall (hazard unit) and EX redirect (taken branch/jump, target computed from the extended immediate).

---
 rtl/fetch_ifid_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Keeps one imem request in flight; handles ID stall and EX redirect.
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  localparam logic [1:0] StFetch = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;
  localparam logic [1:0] StDrop  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;

  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    deliver       = 1'b0;
    deliver_instr = '0;
    deliver_pc    = '0;

    if (redirect_valid) begin
      // Flush beats stall; any response still owed becomes stale and is dropped.
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      case (state_q)
        StFetch: state_d = imem_gnt ? StDrop : StFetch;
        StHold:  state_d = StFetch;
        default: state_d = imem_rvalid ? StFetch : StDrop;
      endcase
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = StWait;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            if (id_stall) begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = req_pc_q;
              state_d      = StHold;
            end else begin
              deliver       = 1'b1;
              deliver_instr = imem_rdata;
              deliver_pc    = req_pc_q;
              state_d       = StFetch;
            end
          end
        end
        StHold: begin
          if (!id_stall) begin
            deliver       = 1'b1;
            deliver_instr = skid_instr_q;
            deliver_pc    = skid_pc_q;
            state_d       = StFetch;
          end
        end
        default: begin
          if (imem_rvalid) state_d = StFetch;
        end
      endcase

      if (deliver) begin
        id_valid_d    = 1'b1;
        id_instr_d    = deliver_instr;
        id_pc_d       = deliver_pc;
        id_pc_plus4_d = deliver_pc + 32'd4;
      end else if (!id_stall) begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= '0;
      id_pc_plus4_q <= 32'd4;
      id_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
    end
  end

  assign imem_req    = (state_q == StFetch) && !rst;
  assign imem_addr   = pc_q & 32'hFFFF_FFFC;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;

endmodule
